full_adder_reg: RTL and testbench



---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 16 +
 rtl/full_adder_reg.sv | 59 +++++
 tb/tb_full_adder_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width limit and golden-sum helper for the registered ripple adder
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Callers mask operands to their own width; the result carries one extra bit.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin
    );
        return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_reg.sv
// full_adder_reg: WIDTH-bit ripple-carry adder with registered sum/carry_out and valid qualifier.
// Define FULL_ADDER_REG_OVERFLOW_EN to add a registered signed-overflow output.
module full_adder_reg
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef FULL_ADDER_REG_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             carry_out
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = carry_in;

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Data registers load only on in_valid, so junk on idle inputs never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef FULL_ADDER_REG_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= s;
                carry_out <= c[WIDTH];
`ifdef FULL_ADDER_REG_OVERFLOW_EN
                overflow  <= c[WIDTH] ^ c[WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_full_adder_reg.sv
// tb_full_adder_reg: randomized and directed checks of full_adder_reg at WIDTH=1, 8 and 16
module tb_full_adder_reg;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int          wd[3] = '{1, 8, 16};
    logic [15:0] msk[3] = '{16'h0001, 16'h00ff, 16'hffff};
    logic [15:0] ia[3], ib[3];
    logic        ic[3], iv[3];

    longint ms[3], mc[3], mo[3], mv[3];

    logic [0:0]  s1;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        co1, co8, co16, vo1, vo8, vo16;
`ifdef FULL_ADDER_REG_OVERFLOW_EN
    logic        ov1, ov8, ov16;
`endif

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .a(ia[0][0:0]), .b(ib[0][0:0]),
        .carry_in(ic[0]), .out_valid(vo1), .sum(s1),
`ifdef FULL_ADDER_REG_OVERFLOW_EN
        .overflow(ov1),
`endif
        .carry_out(co1)
    );

    full_adder_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .a(ia[1][7:0]), .b(ib[1][7:0]),
        .carry_in(ic[1]), .out_valid(vo8), .sum(s8),
`ifdef FULL_ADDER_REG_OVERFLOW_EN
        .overflow(ov8),
`endif
        .carry_out(co8)
    );

    full_adder_reg #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .a(ia[2]), .b(ib[2]),
        .carry_in(ic[2]), .out_valid(vo16), .sum(s16),
`ifdef FULL_ADDER_REG_OVERFLOW_EN
        .overflow(ov16),
`endif
        .carry_out(co16)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signed overflow: the true signed total falls outside the w-bit two's-complement range.
    function automatic longint ovf_ref(input int w, input longint a, input longint b, input longint cin);
        longint half, sa, sb, t;
        half = longint'(1) << (w - 1);
        sa = (a >= half) ? a - 2 * half : a;
        sb = (b >= half) ? b - 2 * half : b;
        t = sa + sb + cin;
        return (t >= half || t < -half) ? 1 : 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            ms[i] = 0; mc[i] = 0; mo[i] = 0; mv[i] = 0;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":v1"}, longint'(vo1), mv[0]);
        chk({ph, ":s1"}, longint'(s1), ms[0]);
        chk({ph, ":c1"}, longint'(co1), mc[0]);
        chk({ph, ":v8"}, longint'(vo8), mv[1]);
        chk({ph, ":s8"}, longint'(s8), ms[1]);
        chk({ph, ":c8"}, longint'(co8), mc[1]);
        chk({ph, ":v16"}, longint'(vo16), mv[2]);
        chk({ph, ":s16"}, longint'(s16), ms[2]);
        chk({ph, ":c16"}, longint'(co16), mc[2]);
`ifdef FULL_ADDER_REG_OVERFLOW_EN
        chk({ph, ":o1"}, longint'(ov1), mo[0]);
        chk({ph, ":o8"}, longint'(ov8), mo[1]);
        chk({ph, ":o16"}, longint'(ov16), mo[2]);
`endif
    endtask

    // Inputs change only after a negedge, so the model may read them at the posedge.
    task automatic tick(input string ph);
        longint r;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] = longint'(iv[i]);
                if (iv[i]) begin
                    r = longint'(ia[i] & msk[i]) + longint'(ib[i] & msk[i]) + longint'(ic[i]);
                    ms[i] = r & longint'(msk[i]);
                    mc[i] = (r >> wd[i]) & 1;
                    mo[i] = ovf_ref(wd[i], longint'(ia[i] & msk[i]), longint'(ib[i] & msk[i]), longint'(ic[i]));
                end
            end
        end
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic rnd(input int i, input bit valid_always);
        ia[i] = 16'($urandom) & msk[i];
        ib[i] = 16'($urandom) & msk[i];
        ic[i] = 1'($urandom);
        iv[i] = valid_always ? 1'b1 : 1'($urandom);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        ia[1] = {8'h00, a}; ib[1] = {8'h00, b}; ic[1] = c; iv[1] = v;
    endtask

    logic [1:0] t1[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        clear_model();
        for (int i = 0; i < 3; i++) begin
            ia[i] = '0; ib[i] = '0; ic[i] = 1'b0; iv[i] = 1'b0;
        end
        @(negedge clk);
        check_all("rst0");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) rnd(i, 1'b1);
            tick("rst_hold");
        end
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            ia[0] = 16'((k >> 2) & 1); ib[0] = 16'((k >> 1) & 1); ic[0] = 1'((k) & 1); iv[0] = 1'b1;
            rnd(1, 1'b0); rnd(2, 1'b1);
            tick("w1_exh");
            chk("w1_table", longint'({co1, s1}), longint'(t1[k]));
        end

        drive8(8'hff, 8'h00, 1'b1, 1'b1);
        tick("wrap0");
        chk("wrap0_s", longint'(s8), 0);
        chk("wrap0_c", longint'(co8), 1);
        drive8(8'hff, 8'hff, 1'b1, 1'b1);
        tick("wrap1");
        chk("wrap1_s", longint'(s8), 'hff);
        chk("wrap1_c", longint'(co8), 1);
        drive8(8'h00, 8'h00, 1'b0, 1'b1);
        tick("zero");
        chk("zero_sc", longint'({co8, s8}), 0);

        drive8(8'h12, 8'h34, 1'b0, 1'b1);
        tick("hold0");
        chk("hold0_s", longint'(s8), 'h46);
        chk("hold0_v", longint'(vo8), 1);
        drive8(8'haa, 8'h55, 1'b1, 1'b0);
        tick("hold1");
        chk("hold1_s", longint'(s8), 'h46);
        chk("hold1_v", longint'(vo8), 0);

`ifdef FULL_ADDER_REG_OVERFLOW_EN
        drive8(8'h7f, 8'h01, 1'b0, 1'b1);
        tick("ovf0");
        chk("ovf0_s", longint'(s8), 'h80);
        chk("ovf0_o", longint'(ov8), 1);
        chk("ovf0_c", longint'(co8), 0);
        drive8(8'h80, 8'hff, 1'b0, 1'b1);
        tick("ovf1");
        chk("ovf1_s", longint'(s8), 'h7f);
        chk("ovf1_o", longint'(ov8), 1);
        chk("ovf1_c", longint'(co8), 1);
`endif

        for (int k = 0; k < 1000; k++) begin
            rnd(0, 1'b0); rnd(1, 1'b0); rnd(2, 1'b1);
            tick("rand");
        end

        // Reset asserted between edges must clear outputs without a clock.
        for (int i = 0; i < 3; i++) begin
            ia[i] = msk[i]; ib[i] = msk[i]; ic[i] = 1'b1; iv[i] = 1'b1;
        end
        tick("pre_arst");
        #1 rst_n = 1'b0;
        #1;
        clear_model();
        check_all("arst");
        for (int i = 0; i < 3; i++) rnd(i, 1'b1);
        tick("arst_hold");
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) rnd(i, 1'b1);
            tick("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
